cache_axi_slave_mem: RTL and testbench



---
 rtl/cache_axi_slave_mem.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cache_axi_slave_mem.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_slave_mem.sv
// AXI4 slave backed by a word-addressed dual-port RAM; main memory model for the cache.
module cache_axi_slave_mem #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_ID_W   = 1,
    parameter int unsigned AXI_LEN_W  = 8,
    parameter int unsigned MEM_ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [AXI_LEN_W-1:0]    s_axi_awlen,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [AXI_LEN_W-1:0]    s_axi_arlen,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned BYTE_W = $clog2(AXI_DATA_W/8);
    localparam int unsigned STRB_W = AXI_DATA_W/8;
    localparam int unsigned DEPTH  = 1 << MEM_ADDR_W;
    localparam int unsigned CNT_W  = AXI_LEN_W + 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    // Write channel state and datapath
    w_state_e              w_state_q, w_state_d;
    logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
    logic [MEM_ADDR_W-1:0] w_idx_q, w_idx_d;
    logic [AXI_LEN_W-1:0]  w_len_q, w_len_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [CNT_W-1:0]      w_cnt_q, w_cnt_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  mem_we_c;

    // Read channel state and datapath
    r_state_e              r_state_q, r_state_d;
    logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
    logic [MEM_ADDR_W-1:0] r_idx_q, r_idx_d;
    logic [AXI_LEN_W-1:0]  r_len_q, r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [AXI_LEN_W-1:0]  r_cnt_q, r_cnt_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [AXI_DATA_W-1:0] rdata_q;

    // Address bits outside the word index are intentionally ignored (aliasing)
    logic unused_addr_c;
    assign unused_addr_c = ^{s_axi_awaddr, s_axi_araddr};

    // Write FSM state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Write FSM next state; beat counter saturates so overlong bursts cannot wrap it
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        mem_we_c  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    w_id_d    = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
                    w_len_d   = s_axi_awlen;
                    w_burst_d = s_axi_awburst;
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    mem_we_c = (w_cnt_q <= CNT_W'(w_len_q)) && (w_burst_q != BURST_RSVD);
                    w_cnt_d  = (w_cnt_q == '1) ? w_cnt_q : w_cnt_q + CNT_W'(1);
                    if (w_burst_q != BURST_FIXED) begin
                        w_idx_d = w_idx_q + MEM_ADDR_W'(1);
                    end
                    if (s_axi_wlast) begin
                        bresp_d = ((w_cnt_q != CNT_W'(w_len_q)) || (w_burst_q == BURST_RSVD))
                                  ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel outputs, registered from the next state
    always_comb begin
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // RAM write port with byte enables
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // Read FSM next state: one fetch cycle precedes every data beat
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    r_id_d    = s_axi_arid;
                    r_idx_d   = s_axi_araddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
                    r_len_d   = s_axi_arlen;
                    r_burst_d = s_axi_arburst;
                    r_cnt_d   = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q + AXI_LEN_W'(1);
                        if (r_burst_q != BURST_FIXED) begin
                            r_idx_d = r_idx_q + MEM_ADDR_W'(1);
                        end
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read channel outputs, registered from the next state
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rlast_d   = (r_state_d == R_DATA) && (r_cnt_d == r_len_d);
        rresp_d   = ((r_state_d == R_DATA) && (r_burst_d == BURST_RSVD)) ? RESP_SLVERR : RESP_OKAY;
    end

    // RAM synchronous read port; old data wins on a same-cycle write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (r_state_q == R_FETCH) begin
            rdata_q <= (r_burst_q == BURST_RSVD) ? '0 : mem[r_idx_q];
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rid     = r_id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_cache_axi_slave_mem.sv
// Scoreboard bench for cache_axi_slave_mem: reference memory model, expected-beat queues.
module tb_cache_axi_slave_mem;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 1;
    localparam int unsigned LW = 8;
    localparam int unsigned MW = 10;
    localparam int TMO = 60;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [LW-1:0] awlen, arlen;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;

    cache_axi_slave_mem #(
        .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .AXI_LEN_W(LW), .MEM_ADDR_W(MW)
    ) dut (
        .clk(clk), .reset(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } rexp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic       id;
    } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] model [1024];
    logic [31:0] wbuf [16];
    logic [31:0] last_rdata;
    int          n_checks;
    int          n_fail;

    // Count a comparison and report a mismatch
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full write transaction: updates the model, queues the expected B, drives AW/W/B
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic id, input int nbeats, input logic [3:0] strb);
        logic [9:0] idx;
        bexp_t      be;
        int         t;
        idx = addr[11:2];
        for (int b = 0; b < nbeats; b++) begin
            if (b <= len && burst != 2'b11) begin
                for (int k = 0; k < 4; k++) begin
                    if (strb[k]) model[idx][k*8 +: 8] = wbuf[b][k*8 +: 8];
                end
            end
            if (burst != 2'b00) idx = idx + 10'd1;
        end
        be.resp = ((nbeats - 1) != len || burst == 2'b11) ? 2'b10 : 2'b00;
        be.id   = id;
        bq.push_back(be);

        awid = id; awaddr = addr; awlen = LW'(len); awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check_eq("aw_timeout", 64'd0, 64'd1);
        @(negedge clk);
        awvalid = 1'b0;

        for (int b = 0; b < nbeats; b++) begin
            wdata = wbuf[b]; wstrb = strb; wlast = (b == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) check_eq("w_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;

        t = 0;
        while (!bvalid && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) begin
            check_eq("b_timeout", 64'd0, 64'd1);
            void'(bq.pop_front());
        end else begin
            be = bq.pop_front();
            check_eq("bresp", 64'(bresp), 64'(be.resp));
            check_eq("bid", 64'(bid), 64'(be.id));
            @(negedge clk);
            check_eq("awready_after_b", 64'(awready), 64'd1);
        end
    endtask

    // Full read transaction: queues expected beats from the model, then pops and compares each R beat
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic id, input bit hold);
        logic [9:0]  idx;
        rexp_t       e;
        int          t;
        logic [31:0] cap_d;
        logic        cap_l;
        idx = addr[11:2];
        for (int b = 0; b <= len; b++) begin
            e.data = (burst == 2'b11) ? 32'h0 : model[idx];
            e.resp = (burst == 2'b11) ? 2'b10 : 2'b00;
            e.last = (b == len);
            e.id   = id;
            rq.push_back(e);
            if (burst != 2'b00) idx = idx + 10'd1;
        end

        rready = !hold;
        arid = id; araddr = addr; arlen = LW'(len); arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) check_eq("ar_timeout", 64'd0, 64'd1);
        @(negedge clk);
        arvalid = 1'b0;

        for (int b = 0; b <= len; b++) begin
            t = 1;
            while (!rvalid && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) begin
                check_eq("r_timeout", 64'd0, 64'd1);
                rq.delete();
                rready = 1'b1;
                return;
            end
            check_eq(b == 0 ? "r_first_latency" : "r_beat_spacing", 64'(t), 64'd2);
            if (hold && b == 0) begin
                cap_d = rdata;
                cap_l = rlast;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("r_hold_stable", {31'd0, rvalid, rlast, rdata}, {31'd0, 1'b1, cap_l, cap_d});
                end
                rready = 1'b1;
            end
            e = rq.pop_front();
            check_eq("rdata", 64'(rdata), 64'(e.data));
            check_eq("rresp", 64'(rresp), 64'(e.resp));
            check_eq("rlast", 64'(rlast), 64'(e.last));
            check_eq("rid", 64'(rid), 64'(e.id));
            last_rdata = rdata;
            @(negedge clk);
        end
        rready = 1'b1;
    endtask

    initial begin
        int t;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        repeat (3) @(negedge clk);

        check_eq("rst_readies", {60'd0, awready, arready, wready, bvalid}, {60'd0, 4'b1100});
        check_eq("rst_r", {61'd0, rvalid, rlast, rid}, 64'd0);
        check_eq("rst_rdata", 64'(rdata), 64'd0);
        check_eq("rst_resp", {60'd0, bresp, rresp}, 64'd0);
        check_eq("rst_bid", 64'(bid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write then read
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h10, 0, 2'b01, 1'b1, 1, 4'hF);
        axi_read(32'h10, 0, 2'b01, 1'b1, 1'b0);
        check_eq("single_value", 64'(last_rdata), 64'hDEADBEEF);

        // 8-beat INCR
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i);
        axi_write(32'h100, 7, 2'b01, 1'b0, 8, 4'hF);
        axi_read(32'h100, 7, 2'b01, 1'b0, 1'b0);

        // byte strobes
        wbuf[0] = 32'hFFFFFFFF;
        axi_write(32'h200, 0, 2'b01, 1'b0, 1, 4'hF);
        wbuf[0] = 32'h00000000;
        axi_write(32'h200, 0, 2'b01, 1'b0, 1, 4'h5);
        axi_read(32'h200, 0, 2'b01, 1'b0, 1'b0);
        check_eq("strobe_value", 64'(last_rdata), 64'hFF00FF00);

        // read back-pressure
        axi_read(32'h104, 1, 2'b01, 1'b1, 1'b1);

        // early wlast: SLVERR and only two words written
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h11110000 + 32'(i);
        axi_write(32'h300, 3, 2'b01, 1'b0, 4, 4'hF);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h22220000 + 32'(i);
        axi_write(32'h300, 3, 2'b01, 1'b1, 2, 4'hF);
        axi_read(32'h300, 3, 2'b01, 1'b0, 1'b0);
        check_eq("early_wlast_untouched", 64'(last_rdata), 64'h11110003);

        // reserved burst read and write
        axi_read(32'h10, 2, 2'b11, 1'b1, 1'b0);
        wbuf[0] = 32'h12345678;
        axi_write(32'h10, 0, 2'b11, 1'b0, 1, 4'hF);
        axi_read(32'h10, 0, 2'b01, 1'b0, 1'b0);
        check_eq("rsvd_write_suppressed", 64'(last_rdata), 64'hDEADBEEF);

        // aliasing of upper address bits
        wbuf[0] = 32'hA5;
        axi_write(32'h1000, 0, 2'b01, 1'b0, 1, 4'hF);
        axi_read(32'h0, 0, 2'b01, 1'b0, 1'b0);
        check_eq("alias_value", 64'(last_rdata), 64'hA5);

        // index wrap at the top of the RAM
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        axi_write(32'hFFC, 1, 2'b01, 1'b1, 2, 4'hF);
        axi_read(32'h0, 0, 2'b01, 1'b0, 1'b0);
        check_eq("wrap_value", 64'(last_rdata), 64'hCAFE0002);
        axi_read(32'hFFC, 1, 2'b01, 1'b1, 1'b0);

        // FIXED burst keeps only the last beat
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hF1000000 + 32'(i);
        axi_write(32'h400, 3, 2'b00, 1'b0, 4, 4'hF);
        axi_read(32'h400, 0, 2'b01, 1'b0, 1'b0);
        check_eq("fixed_value", 64'(last_rdata), 64'hF1000003);
        axi_read(32'h400, 2, 2'b00, 1'b0, 1'b0);

        // asynchronous reset in the middle of a read burst
        rready = 1'b0;
        arid = 1'b1; araddr = 32'h100; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TMO) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < TMO) begin @(negedge clk); t++; end
        check_eq("mid_reset_rvalid_before", 64'(rvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_reset_rvalid", 64'(rvalid), 64'd0);
        check_eq("mid_reset_outs", {61'd0, arready, rlast, rid}, {61'd0, 3'b100});
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        axi_read(32'h100, 7, 2'b01, 1'b0, 1'b0);
        check_eq("post_reset_value", 64'(last_rdata), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
